// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : First-word-fall-through receive buffer for completed UART frames.
//            Each entry holds the payload and its parity-check result.
// Revision : 1.0 - initial release
// ============================================================================

module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [DATA_WIDTH-1:0] rx_dout,
  input  logic                  rx_parity_ok,
  input  logic                  rd_uart,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_parity_ok,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int                DEPTH      = 2 ** ADDR_WIDTH;
  localparam int                WORD_WIDTH = DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   C_DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   C_COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  push_en;
  logic                  pop_en;
  logic                  mem_we;
  logic [WORD_WIDTH-1:0] head_word;

  // Flags come from the count register so full and empty are never ambiguous
  // when the pointers coincide.
  assign empty = (count_q == '0);
  assign full  = (count_q == C_DEPTH);

  always_comb begin
    push_en    = rx_done_tick && (!full || rd_uart);
    pop_en     = rd_uart && !empty;
    mem_we     = push_en && !reset;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + C_COUNT_ONE;
      2'b01:   count_d = count_q - C_COUNT_ONE;
      default: count_d = count_q;
    endcase

    // A dropped frame outranks a simultaneous clear.
    if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (rx_done_tick && !push_en) begin
      overflow_d = 1'b1;
    end

    if (reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    count_q    <= count_d;
    overflow_q <= overflow_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {rx_parity_ok, rx_dout};
    end
  end

  assign head_word   = mem_q[rd_ptr_q];
  assign r_data      = head_word[DATA_WIDTH-1:0];
  assign r_parity_ok = head_word[DATA_WIDTH];
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       rx_parity_ok = 1'b0;
  logic       rd_uart = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] r_data;
  logic       r_parity_ok;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic [8:0] seen_head;
  logic [8:0] exp_head;
  logic       head_valid;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rx_parity_ok (rx_parity_ok),
    .rd_uart      (rd_uart),
    .clr_overflow (clr_overflow),
    .r_data       (r_data),
    .r_parity_ok  (r_parity_ok),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  // One clock cycle: drive at the falling edge, record the head the consumer
  // sees, advance the model at the rising edge, release inputs shortly after.
  task automatic drive(input bit push, input logic [8:0] w, input bit pop,
                       input bit clr, input bit rst);
    int  n;
    bit  took;
    @(negedge clk);
    rx_done_tick = push;
    rx_parity_ok = w[8];
    rx_dout      = w[7:0];
    rd_uart      = pop;
    clr_overflow = clr;
    reset        = rst;
    #1;
    seen_head  = {r_parity_ok, r_data};
    head_valid = (m_q.size() > 0);
    exp_head   = head_valid ? m_q[0] : 9'h000;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      n    = m_q.size();
      took = push && (n < DEPTH || pop);
      if (pop && n > 0) void'(m_q.pop_front());
      if (took) m_q.push_back(w);
      if (push && !took) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
    rx_done_tick = 1'b0;
    rd_uart      = 1'b0;
    clr_overflow = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b1, 9'h1AA, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (count !== 5'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", count);
    end
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got e=%b f=%b o=%b want e=1 f=0 o=0", empty, full, overflow);
    end
  endtask

  task automatic test_single;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 9'h1A5, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (empty !== 1'b0 || count !== 5'd1) begin
      miscompares++; $display("FAIL single_push: got e=%b c=%0d want e=0 c=1", empty, count);
    end
    vectors++;
    if ({r_parity_ok, r_data} !== 9'h1A5) begin
      miscompares++; $display("FAIL single_head: got %h want 1a5", {r_parity_ok, r_data});
    end
    drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (seen_head !== 9'h1A5 || empty !== 1'b1 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL single_pop: got head=%h e=%b c=%0d want 1a5 1 0", seen_head, empty, count);
    end
  endtask

  task automatic test_fill_overflow;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, {i[0], 8'(i)}, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill: got f=%b c=%0d o=%b want 1 16 0", full, count, overflow);
    end
    drive(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      miscompares++; $display("FAIL drop: got o=%b c=%0d want 1 16", overflow, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (seen_head !== {i[0], 8'(i)}) begin
        miscompares++; $display("FAIL drain_order[%0d]: got %h want %h", i, seen_head, {i[0], 8'(i)});
      end
    end
    vectors++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL drained: got e=%b o=%b want 1 1", empty, overflow);
    end
  endtask

  task automatic test_full_push_pop;
    logic [8:0] last;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, {1'b1, 8'(i)}, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h155, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (seen_head !== 9'h100 || count !== 5'd16 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pushpop: got head=%h c=%0d o=%b want 100 16 0", seen_head, count, overflow);
    end
    last = 9'h000;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
      last = seen_head;
    end
    vectors++;
    if (last !== 9'h155 || empty !== 1'b1) begin
      miscompares++; $display("FAIL full_pushpop_last: got %h e=%b want 155 1", last, empty);
    end
  endtask

  task automatic test_empty_push_pop;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 9'h03C, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (count !== 5'd1 || {r_parity_ok, r_data} !== 9'h03C) begin
      miscompares++;
      $display("FAIL empty_pushpop: got c=%0d head=%h want 1 03c", count, {r_parity_ok, r_data});
    end
    drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_empty: got c=%0d e=%b o=%b want 0 1 0", count, empty, overflow);
    end
  endtask

  task automatic test_wrap;
    int pushes;
    int cycles;
    bit psh;
    bit pp;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    pushes = 0;
    cycles = 0;
    while (pushes < 40 && cycles < 1000) begin
      psh = (m_q.size() < 15) && ($urandom_range(0, 2) != 0);
      pp  = (m_q.size() > 1) && ($urandom_range(0, 2) != 0);
      drive(psh, 9'($urandom), pp, 1'b0, 1'b0);
      if (psh) pushes++;
      cycles++;
      if (pp) begin
        vectors++;
        if (seen_head !== exp_head) begin
          miscompares++; $display("FAIL wrap_head: got %h want %h", seen_head, exp_head);
        end
      end
    end
    vectors++;
    if (pushes < 40) begin
      miscompares++; $display("FAIL wrap_budget: got %0d pushes want 40", pushes);
    end
    while (m_q.size() > 0) begin
      drive(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (seen_head !== exp_head) begin
        miscompares++; $display("FAIL wrap_drain: got %h want %h", seen_head, exp_head);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) drive(1'b1, 9'($urandom), 1'b0, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      miscompares++; $display("FAIL burst_ovf: got o=%b c=%0d want 1 16", overflow, count);
    end
    drive(1'b1, 9'h0EE, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got c=%0d e=%b o=%b want 0 1 0", count, empty, overflow);
    end
    for (int i = 0; i < 17; i++) drive(1'b1, 9'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h077, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++; $display("FAIL clr_vs_drop: got %b want 1", overflow);
    end
    drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      miscompares++; $display("FAIL clr: got o=%b c=%0d want 0 16", overflow, count);
    end
  endtask

  task automatic test_random;
    bit psh;
    bit pp;
    bit rst;
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      psh = ($urandom_range(0, 1) == 1);
      pp  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 63) == 0);
      drive(psh, 9'($urandom), pp, ($urandom_range(0, 15) == 0), rst);
      vectors++;
      if (count !== 5'(m_q.size())) begin
        miscompares++; $display("FAIL rnd_count: got %0d want %0d", count, m_q.size());
      end
      vectors++;
      if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin
        miscompares++; $display("FAIL rnd_flags: got e=%b f=%b size %0d", empty, full, m_q.size());
      end
      vectors++;
      if (overflow !== m_ovf) begin
        miscompares++; $display("FAIL rnd_ovf: got %b want %b", overflow, m_ovf);
      end
      if (pp && head_valid && !rst) begin
        vectors++;
        if (seen_head !== exp_head) begin
          miscompares++; $display("FAIL rnd_pop: got %h want %h", seen_head, exp_head);
        end
      end
      if (m_q.size() > 0) begin
        vectors++;
        if ({r_parity_ok, r_data} !== m_q[0]) begin
          miscompares++; $display("FAIL rnd_head: got %h want %h", {r_parity_ok, r_data}, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
